// File: rtl/write_to_ram_from_uart.sv
// write_to_ram_from_uart: parses ASCII hex lines from a UART byte strobe and writes them to sequential RAM words.
// Optional LOWERCASE_HEX_EN accepts 'a'-'f' as hex digits.
module write_to_ram_from_uart #(
    parameter int ADDR_W = 6,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rx_valid,
    input  logic [7:0]          uart_rx_data,
    output logic [ADDR_W-1:0]   address_to_ram,
    output logic [4*DIGITS-1:0] data_to_ram,
    output logic                write_enable_to_ram,
    output logic                line_error,
    output logic                ram_full
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    typedef enum logic [1:0] {S_DIGIT, S_DISCARD, S_WRITE, S_FULL} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [DW-1:0]       sr, sr_n, data_n;
    logic [ADDR_W-1:0]   addr_n;
    logic                full_n, err_n, is_digit, is_hex, is_lf, is_cr;
    logic [3:0]          nib;

    // Letters of either case share the low nibble, so +9 maps 'A'/'a' to 10.
    always_comb begin
        is_digit = uart_rx_data >= 8'h30 && uart_rx_data <= 8'h39;
`ifdef LOWERCASE_HEX_EN
        is_hex   = is_digit || (uart_rx_data >= 8'h41 && uart_rx_data <= 8'h46)
                            || (uart_rx_data >= 8'h61 && uart_rx_data <= 8'h66);
`else
        is_hex   = is_digit || (uart_rx_data >= 8'h41 && uart_rx_data <= 8'h46);
`endif
        nib      = is_digit ? uart_rx_data[3:0] : uart_rx_data[3:0] + 4'd9;
        is_lf    = uart_rx_data == 8'h0A;
        is_cr    = uart_rx_data == 8'h0D;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        data_n  = data_to_ram;
        addr_n  = address_to_ram;
        full_n  = ram_full;
        err_n   = 1'b0;
        case (state)
            S_DIGIT: if (uart_rx_valid) begin
                if (is_hex) begin
                    if (cnt == CNT_MAX) begin
                        err_n   = 1'b1;
                        state_n = S_DISCARD;
                    end else begin
                        sr_n  = {sr[DW-5:0], nib};
                        cnt_n = cnt + 1'b1;
                    end
                end else if (is_lf) begin
                    cnt_n = '0;
                    if (cnt == CNT_MAX) begin
                        data_n  = sr;
                        state_n = S_WRITE;
                    end else begin
                        err_n = cnt != '0;
                    end
                end else if (!is_cr) begin
                    err_n   = 1'b1;
                    state_n = S_DISCARD;
                end
            end
            S_DISCARD: if (uart_rx_valid && is_lf) begin
                cnt_n   = '0;
                state_n = S_DIGIT;
            end
            S_WRITE: begin
                err_n = uart_rx_valid;
                if (&address_to_ram) begin
                    full_n  = 1'b1;
                    state_n = S_FULL;
                end else begin
                    addr_n  = address_to_ram + 1'b1;
                    state_n = S_DIGIT;
                end
            end
            S_FULL: state_n = S_FULL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_DIGIT;
            cnt            <= '0;
            sr             <= '0;
            data_to_ram    <= '0;
            address_to_ram <= '0;
            ram_full       <= 1'b0;
            line_error     <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            sr             <= sr_n;
            data_to_ram    <= data_n;
            address_to_ram <= addr_n;
            ram_full       <= full_n;
            line_error     <= err_n;
        end
    end

    assign write_enable_to_ram = state == S_WRITE;
endmodule

// File: tb/tb_write_to_ram_from_uart.sv
// tb_write_to_ram_from_uart: directed hex-line stimulus with hand-computed expected writes and errors.
module tb_write_to_ram_from_uart;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic [5:0]  address_to_ram;
    logic [15:0] data_to_ram;
    logic        write_enable_to_ram, line_error, ram_full;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic [5:0]  wa[$];
    logic [15:0] wd[$];
    int wbase, ebase;

    write_to_ram_from_uart dut (
        .clk(clk), .reset(reset), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .address_to_ram(address_to_ram), .data_to_ram(data_to_ram),
        .write_enable_to_ram(write_enable_to_ram), .line_error(line_error), .ram_full(ram_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (write_enable_to_ram) begin
            wa.push_back(address_to_ram);
            wd.push_back(data_to_ram);
        end
        if (line_error) err_cnt++;
        if (write_enable_to_ram || line_error) check("excl", {31'd0, write_enable_to_ram & line_error}, 0);
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        @(negedge clk);
        uart_rx_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wbase = wa.size();
        ebase = err_cnt;
    endtask

    function automatic logic [7:0] hexc(input int n);
        string h;
        h = "0123456789ABCDEF";
        return h[n];
    endfunction

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_addr", address_to_ram, 0);
        check("rst_data", data_to_ram, 0);
        check("rst_we", write_enable_to_ram, 0);
        check("rst_err", line_error, 0);
        check("rst_full", ram_full, 0);

        send_str("1A2F\r\n");
        check("t1_nwr", wa.size() - wbase, 1);
        check("t1_addr", wa[wbase], 0);
        check("t1_data", wd[wbase], 16'h1A2F);
        check("t1_nerr", err_cnt - ebase, 0);
        check("t1_next", address_to_ram, 1);
        check("t1_hold", data_to_ram, 16'h1A2F);

        do_reset();
        send_str("12G4\n");
        send_str("00FF\n");
        check("t2_nerr", err_cnt - ebase, 1);
        check("t2_nwr", wa.size() - wbase, 1);
        check("t2_addr", wa[wbase], 0);
        check("t2_data", wd[wbase], 16'h00FF);

        do_reset();
        send_str("123\n");
        check("t3_short_err", err_cnt - ebase, 1);
        check("t3_short_nwr", wa.size() - wbase, 0);
        send_str("12345\n");
        check("t3_long_err", err_cnt - ebase, 2);
        check("t3_long_nwr", wa.size() - wbase, 0);
        check("t3_addr", address_to_ram, 0);
        send_str("\n");
        check("t3_blank_err", err_cnt - ebase, 2);

        do_reset();
        for (int i = 0; i < 64; i++) begin
            send_byte("0", 1'b1);
            send_byte("0", 1'b1);
            send_byte(hexc(i / 16), 1'b1);
            send_byte(hexc(i % 16), 1'b1);
            send_byte(8'h0A, 1'b1);
            @(negedge clk);
        end
        check("t4_nwr", wa.size() - wbase, 64);
        for (int i = 0; i < 64; i++) begin
            check("t4_waddr", wa[wbase + i], i);
            check("t4_wdata", wd[wbase + i], i);
        end
        check("t4_full", ram_full, 1);
        check("t4_addr", address_to_ram, 63);
        send_str("0040\n");
        check("t4_over_nwr", wa.size() - wbase, 64);
        check("t4_over_nerr", err_cnt - ebase, 0);
        check("t4_over_full", ram_full, 1);

        do_reset();
        check("t6_rst_full", ram_full, 0);
        check("t6_rst_addr", address_to_ram, 0);
        send_byte("1", 1'b1);
        send_byte("2", 1'b1);
        do_reset();
        send_str("3456\n");
        check("t6_nwr", wa.size() - wbase, 1);
        check("t6_addr", wa[wbase], 0);
        check("t6_data", wd[wbase], 16'h3456);
        check("t6_nerr", err_cnt - ebase, 0);

        do_reset();
        send_byte("5", 1'b1);
        send_byte("5", 1'b1);
        send_byte("5", 1'b1);
        send_byte("5", 1'b1);
        send_byte(8'h0A, 1'b0);
        send_byte("7", 1'b1);
        repeat (2) @(negedge clk);
        check("t6c_nerr", err_cnt - ebase, 1);
        check("t6c_data", wd[wbase], 16'h5555);
        send_str("0001\n");
        check("t6c_nwr", wa.size() - wbase, 2);
        check("t6c_addr2", wa[wbase + 1], 1);
        check("t6c_data2", wd[wbase + 1], 16'h0001);
        check("t6c_nerr2", err_cnt - ebase, 1);

        do_reset();
        send_str("abcd\n");
`ifdef LOWERCASE_HEX_EN
        check("t5_nwr", wa.size() - wbase, 1);
        check("t5_data", wd[wbase], 16'hABCD);
        check("t5_nerr", err_cnt - ebase, 0);
`else
        check("t5_nwr", wa.size() - wbase, 0);
        check("t5_nerr", err_cnt - ebase, 1);
`endif
        check("t5_addr_after", address_to_ram, wa.size() - wbase);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
